// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU result encodings, flag indices and entry type
package alu_pkg;

    localparam logic [1:0] OSEL_ADD   = 2'b00;
    localparam logic [1:0] OSEL_SHIFT = 2'b01;
    localparam logic [1:0] OSEL_LOGIC = 2'b10;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int ALU_WIDTH = 8;

    typedef struct packed {
        logic [ALU_WIDTH-1:0] y;
        logic                 n;
        logic                 z;
        logic                 c;
        logic                 v;
        logic [1:0]           osel;
    } alu_entry_t;

    function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                              input logic c, input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_result_buffer_if.sv
// rtl/alu_result_buffer_if.sv - producer/consumer bus of the ALU result buffer
interface alu_result_buffer_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
);
    logic                       IN_VALID;
    logic                       IN_READY;
    logic [WIDTH-1:0]           IN_Y;
    logic                       IN_C;
    logic                       IN_V;
    logic [1:0]                 IN_OSEL;
    logic                       OUT_VALID;
    logic                       OUT_READY;
    logic [WIDTH-1:0]           OUT_Y;
    logic [3:0]                 OUT_FLAGS;
    logic [1:0]                 OUT_OSEL;
    logic [3:0]                 STATUS;
    logic                       V_STICKY;
    logic                       CLR_STICKY;
    logic [$clog2(DEPTH):0]     COUNT;

    modport master (
        output IN_VALID, IN_Y, IN_C, IN_V, IN_OSEL, OUT_READY, CLR_STICKY,
        input  IN_READY, OUT_VALID, OUT_Y, OUT_FLAGS, OUT_OSEL, STATUS, V_STICKY, COUNT
    );

    modport slave (
        input  IN_VALID, IN_Y, IN_C, IN_V, IN_OSEL, OUT_READY, CLR_STICKY,
        output IN_READY, OUT_VALID, OUT_Y, OUT_FLAGS, OUT_OSEL, STATUS, V_STICKY, COUNT
    );
endinterface

// File: rtl/alu_fifo_core.sv
// rtl/alu_fifo_core.sv - generic DEPTH-entry FIFO with registered-count ready/valid
module alu_fifo_core #(
    parameter int DEPTH = 2,
    parameter int DW    = 14,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_valid,
    output logic          push_ready,
    input  logic [DW-1:0] push_data,
    output logic          pop_valid,
    input  logic          pop_ready,
    output logic [DW-1:0] pop_data,
    output logic [CW-1:0] count
);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;

    // Ready/valid come only from the registered count: no OUT_READY -> IN_READY path.
    assign push_ready = (count_q != FULL);
    assign pop_valid  = (count_q != '0);
    assign push       = push_valid & push_ready;
    assign pop        = pop_valid & pop_ready;
    assign pop_data   = pop_valid ? mem_q[rp_q] : '0;
    assign count      = count_q;

    always_comb begin
        mem_d   = mem_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        if (push) begin
            mem_d[wp_q] = push_data;
            wp_d        = wp_q + AW'(1);
        end
        if (pop) begin
            rp_d = rp_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q   <= '{default: '0};
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
        end
    end

    assert property (@(posedge clk) disable iff (rst) count_q <= FULL);

endmodule

// File: rtl/alu_result_buffer.sv
// rtl/alu_result_buffer.sv - captures ALU results, derives N/Z, keeps STATUS and sticky V
module alu_result_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic              CLK,
    input  logic              RST,
    alu_result_buffer_if.slave bus
);
    import alu_pkg::*;

    typedef struct packed {
        logic [WIDTH-1:0] y;
        logic             n;
        logic             z;
        logic             c;
        logic             v;
        logic [1:0]       osel;
    } entry_t;

    entry_t     wr_entry;
    entry_t     rd_entry;
    logic       in_ready;
    logic       out_valid;
    logic       push;
    logic [3:0] status_q, status_d;
    logic       v_sticky_q, v_sticky_d;

    // C and V pass through untouched regardless of op class.
    always_comb begin
        wr_entry.y    = bus.IN_Y;
        wr_entry.n    = bus.IN_Y[WIDTH-1];
        wr_entry.z    = (bus.IN_Y == '0);
        wr_entry.c    = bus.IN_C;
        wr_entry.v    = bus.IN_V;
        wr_entry.osel = bus.IN_OSEL;
    end

    alu_fifo_core #(
        .DEPTH (DEPTH),
        .DW    ($bits(entry_t))
    ) u_fifo (
        .clk        (CLK),
        .rst        (RST),
        .push_valid (bus.IN_VALID),
        .push_ready (in_ready),
        .push_data  (wr_entry),
        .pop_valid  (out_valid),
        .pop_ready  (bus.OUT_READY),
        .pop_data   (rd_entry),
        .count      (bus.COUNT)
    );

    assign push = bus.IN_VALID & in_ready;

    always_comb begin
        status_d   = push ? pack_flags(wr_entry.n, wr_entry.z, wr_entry.c, wr_entry.v) : status_q;
        v_sticky_d = (v_sticky_q & ~bus.CLR_STICKY) | (push & bus.IN_V);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            status_q   <= '0;
            v_sticky_q <= 1'b0;
        end else begin
            status_q   <= status_d;
            v_sticky_q <= v_sticky_d;
        end
    end

    assign bus.IN_READY  = in_ready;
    assign bus.OUT_VALID = out_valid;
    assign bus.OUT_Y     = rd_entry.y;
    assign bus.OUT_FLAGS = pack_flags(rd_entry.n, rd_entry.z, rd_entry.c, rd_entry.v);
    assign bus.OUT_OSEL  = rd_entry.osel;
    assign bus.STATUS    = status_q;
    assign bus.V_STICKY  = v_sticky_q;

endmodule

// File: tb/tb_alu_result_buffer.sv
// tb/tb_alu_result_buffer.sv - directed scoreboard bench for alu_result_buffer
module tb_alu_result_buffer;
    localparam int W = 8;
    localparam int D = 2;

    logic CLK;
    logic RST;

    alu_result_buffer_if #(.WIDTH(W), .DEPTH(D)) bus ();

    alu_result_buffer #(.WIDTH(W), .DEPTH(D)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] y;
        logic [3:0] f;
        logic [1:0] o;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         mcount = 0;
    logic       mst = 1'b0;
    logic [3:0] mstat = 4'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_flags(input logic [7:0] y, input logic c, input logic v);
        return {y[7], (y == 8'h00), c, v};
    endfunction

    task automatic drive(input logic valid, input logic [7:0] y, input logic c,
                         input logic v, input logic [1:0] osel);
        bus.IN_VALID = valid;
        bus.IN_Y     = y;
        bus.IN_C     = c;
        bus.IN_V     = v;
        bus.IN_OSEL  = osel;
    endtask

    // One clock: model push/pop decisions, score the head, advance, check state.
    task automatic cycle();
        logic pm, pp;
        exp_t e;
        pm = bus.IN_VALID && (mcount != D);
        pp = bus.OUT_READY && (mcount != 0);
        chk("in_ready", {31'd0, bus.IN_READY}, {31'd0, mcount != D});
        chk("out_valid", {31'd0, bus.OUT_VALID}, {31'd0, mcount != 0});
        if (pp) begin
            e = sb.pop_front();
            chk("out_y", {24'd0, bus.OUT_Y}, {24'd0, e.y});
            chk("out_flags", {28'd0, bus.OUT_FLAGS}, {28'd0, e.f});
            chk("out_osel", {30'd0, bus.OUT_OSEL}, {30'd0, e.o});
        end
        if (pm) begin
            e.y = bus.IN_Y;
            e.f = exp_flags(bus.IN_Y, bus.IN_C, bus.IN_V);
            e.o = bus.IN_OSEL;
            sb.push_back(e);
            mstat = e.f;
        end
        mst    = (mst & ~bus.CLR_STICKY) | (pm & bus.IN_V);
        mcount = mcount + int'(pm) - int'(pp);
        @(posedge CLK);
        #1;
        chk("count", {29'd0, bus.COUNT}, mcount);
        chk("status", {28'd0, bus.STATUS}, {28'd0, mstat});
        chk("v_sticky", {31'd0, bus.V_STICKY}, {31'd0, mst});
    endtask

    initial begin
        RST = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 2'b00);
        bus.OUT_READY  = 1'b0;
        bus.CLR_STICKY = 1'b0;
        #12;
        chk("rst_count", {29'd0, bus.COUNT}, 0);
        chk("rst_in_ready", {31'd0, bus.IN_READY}, 1);
        chk("rst_out_valid", {31'd0, bus.OUT_VALID}, 0);
        chk("rst_out_y", {24'd0, bus.OUT_Y}, 0);
        chk("rst_status", {28'd0, bus.STATUS}, 0);
        chk("rst_v_sticky", {31'd0, bus.V_STICKY}, 0);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Flag derivation: zero result with carry
        drive(1'b1, 8'h00, 1'b1, 1'b0, 2'b00);
        cycle();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 2'b00);
        chk("zero_out_flags", {28'd0, bus.OUT_FLAGS}, 32'h6);
        chk("zero_status", {28'd0, bus.STATUS}, 32'h6);
        bus.OUT_READY = 1'b1;
        cycle();

        // Negative result with overflow
        bus.OUT_READY = 1'b0;
        drive(1'b1, 8'h80, 1'b0, 1'b1, 2'b00);
        cycle();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 2'b00);
        chk("neg_out_flags", {28'd0, bus.OUT_FLAGS}, 32'h9);
        chk("neg_v_sticky", {31'd0, bus.V_STICKY}, 1);
        bus.OUT_READY = 1'b1;
        cycle();

        // V and C pass through on a logical op; push into empty while OUT_READY=1
        drive(1'b1, 8'h3C, 1'b1, 1'b1, 2'b10);
        cycle();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 2'b00);
        chk("logic_out_flags", {28'd0, bus.OUT_FLAGS}, 32'h3);
        chk("logic_out_osel", {30'd0, bus.OUT_OSEL}, 32'h2);
        cycle();

        // Sticky clear alone, then clear racing a V=1 push
        bus.OUT_READY  = 1'b0;
        bus.CLR_STICKY = 1'b1;
        cycle();
        bus.CLR_STICKY = 1'b0;
        chk("clr_alone", {31'd0, bus.V_STICKY}, 0);
        bus.CLR_STICKY = 1'b1;
        drive(1'b1, 8'h7F, 1'b0, 1'b1, 2'b01);
        cycle();
        bus.CLR_STICKY = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 2'b00);
        chk("clr_vs_set", {31'd0, bus.V_STICKY}, 1);
        bus.OUT_READY = 1'b1;
        cycle();

        // Fill, full stall, rejected third result, in-order drain
        bus.OUT_READY = 1'b0;
        drive(1'b1, 8'h11, 1'b0, 1'b0, 2'b00);
        cycle();
        drive(1'b1, 8'h22, 1'b0, 1'b0, 2'b00);
        cycle();
        chk("full_count", {29'd0, bus.COUNT}, 2);
        chk("full_in_ready", {31'd0, bus.IN_READY}, 0);
        drive(1'b1, 8'h33, 1'b0, 1'b0, 2'b00);
        for (int i = 0; i < 2; i++) begin
            cycle();
            chk("stall_hold_y", {24'd0, bus.OUT_Y}, 32'h11);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 2'b00);
        bus.OUT_READY = 1'b1;
        cycle();
        chk("drain_second", {24'd0, bus.OUT_Y}, 32'h22);
        cycle();
        chk("drain_empty_y", {24'd0, bus.OUT_Y}, 0);

        // Simultaneous push and pop at COUNT=1
        bus.OUT_READY = 1'b0;
        drive(1'b1, 8'h05, 1'b0, 1'b0, 2'b00);
        cycle();
        drive(1'b1, 8'h06, 1'b0, 1'b0, 2'b00);
        bus.OUT_READY = 1'b1;
        cycle();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 2'b00);
        chk("pp_count", {29'd0, bus.COUNT}, 1);
        chk("pp_out_y", {24'd0, bus.OUT_Y}, 32'h06);
        cycle();

        // Back-to-back stream through pointer wrap
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b0, 2'b01);
            cycle();
            chk("wrap_count_le1", {31'd0, bus.COUNT <= 1}, 1);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 2'b00);
        cycle();
        chk("wrap_done_valid", {31'd0, bus.OUT_VALID}, 0);

        // Asynchronous reset mid-cycle with two entries buffered
        bus.OUT_READY = 1'b0;
        drive(1'b1, 8'hAA, 1'b0, 1'b1, 2'b00);
        cycle();
        drive(1'b1, 8'hBB, 1'b1, 1'b0, 2'b00);
        cycle();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 2'b00);
        #3;
        RST = 1'b1;
        #1;
        chk("arst_count", {29'd0, bus.COUNT}, 0);
        chk("arst_out_valid", {31'd0, bus.OUT_VALID}, 0);
        chk("arst_in_ready", {31'd0, bus.IN_READY}, 1);
        chk("arst_status", {28'd0, bus.STATUS}, 0);
        chk("arst_v_sticky", {31'd0, bus.V_STICKY}, 0);
        chk("arst_out_y", {24'd0, bus.OUT_Y}, 0);
        sb.delete();
        mcount = 0;
        mst    = 1'b0;
        mstat  = 4'h0;
        @(posedge CLK);
        #1;
        RST = 1'b0;

        drive(1'b1, 8'h5A, 1'b0, 1'b0, 2'b10);
        cycle();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 2'b00);
        chk("post_rst_y", {24'd0, bus.OUT_Y}, 32'h5A);
        bus.OUT_READY = 1'b1;
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
